// File: rtl/cini_pkg.sv
// Shared definitions for the CINI repetition-coded masking datapath.
package cini_pkg;

    localparam int unsigned CINI_N      = 3;
    localparam int unsigned CINI_SHARES = 2;

    typedef enum logic [0:0] {
        CLEAN = 1'b0,
        ALARM = 1'b1
    } cini_det_state_t;

    typedef logic [CINI_N-1:0] cini_word_t;

endpackage

// File: rtl/cini_share_check.sv
// Stage-1 register for a single share: repetition-code consistency flag and decoded bit.
// Each share gets its own instance so share domains never touch in this stage.
module cini_share_check
    import cini_pkg::*;
#(
    parameter int unsigned N = CINI_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_c,
    output logic         o_err,
    output logic         o_dec
);

    logic r_err;
    logic r_dec;
    logic w_all_one;
    logic w_all_zero;

    assign w_all_one  = &i_c;
    assign w_all_zero = ~(|i_c);

    // Register the inconsistency flag and bit 0 of the codeword.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
            r_dec <= 1'b0;
        end else begin
            r_err <= ~(w_all_one | w_all_zero);
            r_dec <= i_c[0];
        end
    end

    assign o_err = r_err;
    assign o_dec = r_dec;

endmodule

// File: rtl/cini_detect_d1_k1.sv
// Consistency-check and decode stage behind the first-order CINI multiplier.
// Stage 1 checks each share separately; stage 2 merges only the error flags, runs the
// alarm FSM and the saturating fault counter, and zeroes data while alarmed.
module cini_detect_d1_k1
    import cini_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned N     = CINI_N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     port_c_0,
    input  logic [N-1:0]     port_c_1,
    input  logic             port_valid_i,
    input  logic             port_clear_i,
    output logic             port_z_0,
    output logic             port_z_1,
    output logic             port_valid_o,
    output logic             port_alarm_o,
    output logic [CNT_W-1:0] port_err_cnt_o
);

    logic [N-1:0]           w_c [CINI_SHARES];
    logic [CINI_SHARES-1:0] w_err;
    logic [CINI_SHARES-1:0] w_dec;

    logic                   r_v1;
    cini_det_state_t        r_state;
    cini_det_state_t        w_state_d;
    logic                   w_fault;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_d;
    logic                   r_z_0;
    logic                   r_z_1;
    logic                   r_valid_o;
    logic                   w_pass;

    assign w_c[0] = port_c_0;
    assign w_c[1] = port_c_1;

    for (genvar s = 0; s < CINI_SHARES; s++) begin : g_share
        cini_share_check #(
            .N (N)
        ) u_share_check (
            .clk   (clk),
            .reset (reset),
            .i_c   (w_c[s]),
            .o_err (w_err[s]),
            .o_dec (w_dec[s])
        );
    end

    // Stage-1 valid travels alongside the per-share registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= port_valid_i;
        end
    end

    // Next state and counter; a fault in the same cycle as clear takes precedence.
    always_comb begin
        w_fault   = r_v1 & (|w_err);
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            CLEAN: if (w_fault) w_state_d = ALARM;
            ALARM: if (port_clear_i && !w_fault) w_state_d = CLEAN;
            default: w_state_d = CLEAN;
        endcase
        if (w_fault) begin
            if (port_clear_i) begin
                w_cnt_d = CNT_W'(1);
            end else if (r_cnt != {CNT_W{1'b1}}) begin
                w_cnt_d = r_cnt + CNT_W'(1);
            end
        end else if (port_clear_i) begin
            w_cnt_d = '0;
        end
        // Data leaves only when valid and the product did not push us into (or keep us in) alarm.
        w_pass = r_v1 & (w_state_d == CLEAN);
    end

    // Stage-2 registers: FSM, counter and infective-zeroed outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CLEAN;
            r_cnt     <= '0;
            r_z_0     <= 1'b0;
            r_z_1     <= 1'b0;
            r_valid_o <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_z_0     <= w_pass & w_dec[0];
            r_z_1     <= w_pass & w_dec[1];
            r_valid_o <= r_v1;
        end
    end

    assign port_z_0       = r_z_0;
    assign port_z_1       = r_z_1;
    assign port_valid_o   = r_valid_o;
    assign port_alarm_o   = (r_state == ALARM);
    assign port_err_cnt_o = r_cnt;

endmodule

// File: tb/tb_cini_detect_d1_k1.sv
// Scoreboard bench for cini_detect_d1_k1: the driver pushes expected outputs from a small
// reference model; a negedge monitor pops and compares whenever port_valid_o is high.
module tb_cini_detect_d1_k1;

    localparam int CNT_W   = 8;
    localparam int N       = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     port_c_0 = '0;
    logic [N-1:0]     port_c_1 = '0;
    logic             port_valid_i = 1'b0;
    logic             port_clear_i = 1'b0;
    logic             port_z_0;
    logic             port_z_1;
    logic             port_valid_o;
    logic             port_alarm_o;
    logic [CNT_W-1:0] port_err_cnt_o;

    always #5 clk = ~clk;

    cini_detect_d1_k1 #(
        .CNT_W (CNT_W),
        .N     (N)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .port_c_0       (port_c_0),
        .port_c_1       (port_c_1),
        .port_valid_i   (port_valid_i),
        .port_clear_i   (port_clear_i),
        .port_z_0       (port_z_0),
        .port_z_1       (port_z_1),
        .port_valid_o   (port_valid_o),
        .port_alarm_o   (port_alarm_o),
        .port_err_cnt_o (port_err_cnt_o)
    );

    typedef struct {
        int z0;
        int z1;
        int alarm;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state (stage 1 and stage 2).
    int   m_v1 = 0, m_e0 = 0, m_e1 = 0, m_d0 = 0, m_d1 = 0;
    int   m_alarm = 0, m_cnt = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int is_err(input logic [N-1:0] c);
        return (c == 3'b000 || c == 3'b111) ? 0 : 1;
    endfunction

    // One clock of stimulus; the model advances right after the edge.
    task automatic step(input logic [N-1:0] c0, input logic [N-1:0] c1,
                        input logic v, input logic clr);
        exp_t e;
        int   fault;
        @(negedge clk);
        reset        = 1'b0;
        port_c_0     = c0;
        port_c_1     = c1;
        port_valid_i = v;
        port_clear_i = clr;
        @(posedge clk);
        #1;
        fault = (m_v1 != 0 && (m_e0 != 0 || m_e1 != 0)) ? 1 : 0;
        if (fault != 0) begin
            m_alarm = 1;
            m_cnt   = (clr) ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
        end else if (clr) begin
            m_alarm = 0;
            m_cnt   = 0;
        end
        if (m_v1 != 0) begin
            e.z0    = (m_alarm == 0) ? m_d0 : 0;
            e.z1    = (m_alarm == 0) ? m_d1 : 0;
            e.alarm = m_alarm;
            e.cnt   = m_cnt;
            q.push_back(e);
        end
        m_v1 = int'(v);
        m_e0 = is_err(c0);
        m_e1 = is_err(c1);
        m_d0 = int'(c0[0]);
        m_d1 = int'(c1[0]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 3'b000, 1'b0, 1'b0);
    endtask

    // Holds reset across one edge; the following step releases it.
    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        port_valid_i = 1'b0;
        port_clear_i = 1'b0;
        @(posedge clk);
        #1;
        m_v1 = 0; m_e0 = 0; m_e1 = 0; m_d0 = 0; m_d1 = 0;
        m_alarm = 0; m_cnt = 0;
    endtask

    // Monitor: every valid output must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (port_valid_o === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: got valid_o=1, expected no output (t=%0t)",
                         $time);
            end else begin
                e = q.pop_front();
                check("z_0", int'(port_z_0), e.z0);
                check("z_1", int'(port_z_1), e.z1);
                check("alarm_on_valid", int'(port_alarm_o), e.alarm);
                check("cnt_on_valid", int'(port_err_cnt_o), e.cnt);
            end
        end
    end

    initial begin
        // Reset state.
        do_reset();
        check("rst_valid_o", int'(port_valid_o), 0);
        check("rst_alarm", int'(port_alarm_o), 0);
        check("rst_cnt", int'(port_err_cnt_o), 0);
        check("rst_z_0", int'(port_z_0), 0);
        check("rst_z_1", int'(port_z_1), 0);

        // Single clean product: z=1/0 two cycles later.
        step(3'b111, 3'b000, 1'b1, 1'b0);
        idle(1);
        check("first_valid_o", int'(port_valid_o), 1);
        check("first_z_0", int'(port_z_0), 1);
        check("first_z_1", int'(port_z_1), 0);
        idle(1);
        check("first_valid_drop", int'(port_valid_o), 0);

        // Five back-to-back clean products.
        step(3'b000, 3'b000, 1'b1, 1'b0);
        step(3'b111, 3'b111, 1'b1, 1'b0);
        step(3'b111, 3'b000, 1'b1, 1'b0);
        step(3'b000, 3'b111, 1'b1, 1'b0);
        step(3'b111, 3'b111, 1'b1, 1'b0);
        idle(2);
        check("stream_alarm", int'(port_alarm_o), 0);

        // Fault on share 0, then a clean product while alarmed.
        step(3'b101, 3'b000, 1'b1, 1'b0);
        step(3'b111, 3'b111, 1'b1, 1'b0);
        idle(1);
        check("fault_alarm", int'(port_alarm_o), 1);
        check("fault_cnt", int'(port_err_cnt_o), 1);
        check("fault_z_0", int'(port_z_0), 0);
        idle(1);
        check("alarmed_z_0", int'(port_z_0), 0);
        check("alarmed_z_1", int'(port_z_1), 0);

        // Two more faults to reach cnt=3, then clear alone.
        step(3'b000, 3'b010, 1'b1, 1'b0);
        step(3'b110, 3'b000, 1'b1, 1'b0);
        idle(2);
        check("cnt3", int'(port_err_cnt_o), 3);
        step(3'b000, 3'b000, 1'b0, 1'b1);
        check("clear_alarm", int'(port_alarm_o), 0);
        check("clear_cnt", int'(port_err_cnt_o), 0);

        // Clear coinciding with a fault in stage 2: fault wins.
        step(3'b000, 3'b010, 1'b1, 1'b0);
        step(3'b000, 3'b000, 1'b0, 1'b1);
        check("clrfault_alarm", int'(port_alarm_o), 1);
        check("clrfault_cnt", int'(port_err_cnt_o), 1);
        idle(1);

        // Saturation: 2^CNT_W + 2 faulty products.
        for (int i = 0; i < (1 << CNT_W) + 2; i++) step(3'b011, 3'b000, 1'b1, 1'b0);
        idle(2);
        check("sat_cnt", int'(port_err_cnt_o), 255);
        check("sat_alarm", int'(port_alarm_o), 1);

        // Faulty word without valid is ignored.
        step(3'b000, 3'b000, 1'b0, 1'b1);
        step(3'b101, 3'b000, 1'b0, 1'b0);
        idle(2);
        check("novalid_alarm", int'(port_alarm_o), 0);
        check("novalid_cnt", int'(port_err_cnt_o), 0);

        // Valid faulty word killed by reset one cycle later.
        step(3'b101, 3'b000, 1'b1, 1'b0);
        do_reset();
        idle(2);
        check("killed_valid_o", int'(port_valid_o), 0);
        check("killed_alarm", int'(port_alarm_o), 0);
        check("killed_cnt", int'(port_err_cnt_o), 0);

        // Clean product after reset still flows.
        step(3'b111, 3'b111, 1'b1, 1'b0);
        idle(3);

        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cini_detect_d1_k1.md
# cini_detect_d1_k1

Consistency-check and decode stage placed directly downstream of the first-order CINI multiplier (2 shares, 3-bit repetition code per share). It takes the registered coded product shares `port_c_0`/`port_c_1`, checks each share's codeword for repetition-code consistency, and emits 1-bit decoded shares. Any detected fault raises a sticky alarm, zeroes the outputs (infective response) and increments a saturating fault counter. Shares are never combined with each other before a register boundary.

## Interface
- `CNT_W`, default 8: width of the fault counter.
- `N`, default 3: code length per share (fixed repetition code; only 3 is supported).

Clock and reset are decided: one clock; reset is synchronous and active-high.

- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `port_c_0`: input, [N-1:0]. Coded share 0 from the multiplier.
- `port_c_1`: input, [N-1:0]. Coded share 1 from the multiplier.
- `port_valid_i`: input, 1 bit. `port_c_*` carry a product this cycle.
- `port_clear_i`: input, 1 bit. Clears alarm and counter.
- `port_z_0`: output, 1 bit. Decoded share 0.
- `port_z_1`: output, 1 bit. Decoded share 1.
- `port_valid_o`: output, 1 bit. `port_z_*` valid.
- `port_alarm_o`: output, 1 bit. Sticky fault flag.
- `port_err_cnt_o`: output, [CNT_W-1:0]. Count of faulty products, saturating.

## Operation
- **Stage 1** (registered, per share only):
  - `err_s` = 1 iff the bits of `port_c_s` are not all equal.
  - `dec_s` = `port_c_s[0]`.
  - `v1` = `port_valid_i`.
  - No logic mixes share 0 and share 1 signals in this stage.
- **Stage 2:**
  - `fault` = `v1 & (err_0 | err_1)`. This is the only point where share-derived flags meet. Flags only are combined, never data bits.
- **FSM**, two states:
  - CLEAN: on `fault`, go to ALARM.
  - ALARM: on `port_clear_i` without `fault`, go to CLEAN. Otherwise stay.
- **Outputs** (registered from stage 2):
  - `port_z_s` = `dec_s` if the next state is CLEAN and `v1`, else 0.
  - `port_valid_o` = `v1`. Valid pulses still propagate in ALARM, with zeroed data.
  - `port_alarm_o` = 1 iff the next state is ALARM. A faulty product therefore leaves with z=0/0 and alarm=1 in the same cycle.
- **Counter:**
  - Increments by 1 on each `fault` cycle.
  - Saturates at 2^CNT_W−1; no wrap.
  - `port_clear_i` sets it to 0.
  - If clear and `fault` occur together: the counter becomes 1 and the state is ALARM. Fault wins.
- **`port_clear_i`** acts in stage 2 only. It does not flush stage 1.
- **Reset:**
  - Every register goes to 0: stage-1 flags/data/valid, FSM = CLEAN, outputs 0, counter 0.
  - Reset mid-stream discards in-flight products; no `port_valid_o` appears for them.
  - Reset has priority over clear and fault.

## Timing
- Latency 2 cycles: `port_valid_i` at edge k gives `port_valid_o` after edge k+2.
- Throughput one product per cycle; no backpressure.
- `port_alarm_o` and `port_err_cnt_o` update in the same cycle as the faulty product's `port_valid_o`.
- Upstream multiplier latency is 2 cycles, so end-to-end operand-to-decoded-share latency is 4 cycles.
- Inputs with `port_valid_i`=0 are ignored for fault detection. Their stage-1 flags are still registered but masked by `v1`.

## Structure
- Shared package `cini_pkg` holds:
  - `CINI_N = 3`, `CINI_SHARES = 2`;
  - state typedef `cini_det_state_t` {CLEAN, ALARM};
  - coded-share typedef `cini_word_t` = logic [CINI_N-1:0].
- One sub-module, `cini_share_check`, instantiated once per share. It is the stage-1 register for one share: codeword in, registered `err` and `dec` out. This keeps share domains physically separate for probing verification.

## Test plan
- Reset, then `port_c_0`=111, `port_c_1`=000, valid for 1 cycle -> 2 cycles later z_0=1, z_1=0, valid_o=1, alarm=0, cnt=0.
- Stream of 5 back-to-back valid codewords (000/111 combinations) -> 5 consecutive valid_o pulses, each z equal to the bit-0 of its share, alarm stays 0.
- `port_c_0`=101, valid -> at +2: z=0/0, alarm=1, cnt=1. The following clean product gives z=0/0 and alarm stays 1.
- In ALARM with cnt=3: assert `port_clear_i` alone -> alarm=0, cnt=0. Next: clear in the same stage-2 cycle as `port_c_1`=010 -> alarm=1, cnt=1.
- Force 2^CNT_W+2 faulty products -> cnt holds at 255 (CNT_W=8), no wrap.
- Faulty word with valid=0 -> no alarm, no count. Valid faulty word followed by reset 1 cycle later -> no valid_o, alarm=0, cnt=0.
